// File: rtl/ps2_rx.sv
// PS/2 device-side receiver: detects a host request-to-send (clock inhibit
// followed by data low), generates the PS/2 clock for 11 bit slots, samples
// start/data/parity/stop, drives the ACK slot and reports the result.
module ps2_rx #(
  parameter int CLK       = 50000000,
  parameter int FREQUENCY = 12000,
  parameter int RTS_US    = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       tx_busy,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV        = CLK / FREQUENCY;
  localparam int RTS_CYCLES = (CLK / 1000000) * RTS_US;
  // Inhibit counter only needs to reach RTS_CYCLES-1.
  localparam int RTS_W      = (RTS_CYCLES > 2) ? $clog2(RTS_CYCLES) : 1;
  // Slot counter is never narrower than 16 bits.
  localparam int CLKD_W     = ($clog2(DIV) > 16) ? $clog2(DIV) : 16;

  localparam logic [RTS_W-1:0]  RTS_LAST    = RTS_W'(RTS_CYCLES - 1);
  localparam logic [CLKD_W-1:0] CLKD_LAST   = CLKD_W'(DIV - 1);
  localparam logic [CLKD_W-1:0] CLKD_HALF   = CLKD_W'(DIV / 2);
  localparam logic [CLKD_W-1:0] CLKD_SAMPLE = CLKD_W'(DIV / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_WAIT_RELEASE,
    ST_CLOCKING,
    ST_ACK
  } state_t;

  state_t              state_q, state_d;
  logic                sclk_meta_q, sclk_meta_d, sclk_q, sclk_d;
  logic                sdat_meta_q, sdat_meta_d, sdat_q, sdat_d;
  logic [RTS_W-1:0]    rts_cnt_q, rts_cnt_d;
  logic [CLKD_W-1:0]   clkd_q, clkd_d;
  logic [3:0]          slot_q, slot_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                stop_q, stop_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;

  // Line drivers follow the registered state, so a reset or abort releases
  // the lines on the very edge that moves the FSM back to IDLE.
  assign ps2_clk_low  = ((state_q == ST_CLOCKING) || (state_q == ST_ACK)) &&
                        (clkd_q >= CLKD_HALF);
  assign ps2_data_low = (state_q == ST_ACK);
  assign busy         = (state_q != ST_IDLE);
  assign data         = data_q;
  assign valid        = valid_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;

  // Next-state logic: synchronizers, request detection, bit clocking and ACK.
  always_comb begin
    sclk_meta_d  = ps2_clk_in;
    sclk_d       = sclk_meta_q;
    sdat_meta_d  = ps2_data_in;
    sdat_d       = sdat_meta_q;
    state_d      = state_q;
    rts_cnt_d    = rts_cnt_q;
    clkd_d       = clkd_q;
    slot_d       = slot_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    stop_d       = stop_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rts_cnt_d = '0;
        clkd_d    = '0;
        if (!sclk_q && !tx_busy) begin
          state_d = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (sclk_q) begin
          state_d   = ST_IDLE;
          rts_cnt_d = '0;
        end else if (rts_cnt_q == RTS_LAST) begin
          state_d = ST_WAIT_RELEASE;
        end else begin
          rts_cnt_d = rts_cnt_q + 1'b1;
        end
      end

      ST_WAIT_RELEASE: begin
        if (sclk_q) begin
          rts_cnt_d = '0;
          if (!sdat_q) begin
            state_d = ST_CLOCKING;
            slot_d  = 4'd0;
            clkd_d  = '0;
          end else begin
            // Plain inhibit without a request: silently return.
            state_d = ST_IDLE;
          end
        end
      end

      ST_CLOCKING: begin
        clkd_d = clkd_q + 1'b1;
        if (clkd_q == CLKD_SAMPLE) begin
          if (!sclk_q) begin
            // Host is holding the clock low during our high phase: abort.
            state_d     = ST_IDLE;
            clkd_d      = '0;
            frame_err_d = 1'b1;
          end else if (slot_q == 4'd0) begin
            if (sdat_q) begin
              state_d     = ST_IDLE;
              clkd_d      = '0;
              frame_err_d = 1'b1;
            end
          end else if (slot_q <= 4'd8) begin
            shift_d = {sdat_q, shift_q[7:1]};
          end else if (slot_q == 4'd9) begin
            parity_d = sdat_q;
          end else begin
            stop_d = sdat_q;
          end
        end else if (clkd_q == CLKD_LAST) begin
          clkd_d = '0;
          if (slot_q == 4'd10) begin
            if (stop_q) begin
              state_d = ST_ACK;
            end else begin
              state_d     = ST_IDLE;
              frame_err_d = 1'b1;
            end
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
      end

      ST_ACK: begin
        clkd_d = clkd_q + 1'b1;
        if (clkd_q == CLKD_LAST) begin
          clkd_d  = '0;
          state_d = ST_IDLE;
          // Odd parity: data bits plus parity bit must XOR to 1.
          if (^{shift_q, parity_q}) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            parity_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        clkd_d  = '0;
      end
    endcase
  end

  // State and data registers with synchronous reset; synchronizers idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_meta_q  <= 1'b1;
      sclk_q       <= 1'b1;
      sdat_meta_q  <= 1'b1;
      sdat_q       <= 1'b1;
      state_q      <= ST_IDLE;
      rts_cnt_q    <= '0;
      clkd_q       <= '0;
      slot_q       <= 4'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      stop_q       <= 1'b0;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_meta_q  <= sclk_meta_d;
      sclk_q       <= sclk_d;
      sdat_meta_q  <= sdat_meta_d;
      sdat_q       <= sdat_d;
      state_q      <= state_d;
      rts_cnt_q    <= rts_cnt_d;
      clkd_q       <= clkd_d;
      slot_q       <= slot_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      stop_q       <= stop_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed testbench for ps2_rx with a scaled clock (DIV=20, RTS_CYCLES=100)
// so that every scenario runs in a few hundred cycles.
module tb_ps2_rx;

  localparam int DIV  = 20;
  localparam int HOLD = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       host_clk = 1'b1;
  logic       host_data = 1'b1;
  logic       tx_busy = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_low, ps2_data_low;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, busy;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in  = host_clk & ~ps2_clk_low;
  assign ps2_data_in = host_data & ~ps2_data_low;

  ps2_rx #(
    .CLK       (1000000),
    .FREQUENCY (50000),
    .RTS_US    (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk_in   (ps2_clk_in),
    .ps2_data_in  (ps2_data_in),
    .tx_busy      (tx_busy),
    .ps2_clk_low  (ps2_clk_low),
    .ps2_data_low (ps2_data_low),
    .data         (data),
    .valid        (valid),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Event monitor: cumulative counts, sampled on the falling edge.
  int   n_valid = 0, n_perr = 0, n_ferr = 0, n_rise = 0, n_ack = 0, n_busy = 0;
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (valid)        n_valid++;
    if (parity_err)   n_perr++;
    if (frame_err)    n_ferr++;
    if (ps2_data_low) n_ack++;
    if (busy)         n_busy++;
    if (ps2_clk_low && !mon_prev) n_rise++;
    mon_prev = ps2_clk_low;
  end

  int total = 0;
  int bad   = 0;
  int b_valid, b_perr, b_ferr, b_rise, b_ack, b_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid; b_perr = n_perr; b_ferr = n_ferr;
    b_rise  = n_rise;  b_ack  = n_ack;  b_busy = n_busy;
  endtask

  task automatic check_events(input string tag, input int v, input int p, input int f,
                              input int rises, input int ack);
    check({tag, "_valid"},  n_valid - b_valid, v);
    check({tag, "_perr"},   n_perr  - b_perr,  p);
    check({tag, "_ferr"},   n_ferr  - b_ferr,  f);
    check({tag, "_rises"},  n_rise  - b_rise,  rises);
    check({tag, "_ackcyc"}, n_ack   - b_ack,   ack);
    check({tag, "_busy"},   busy, 1'b0);
    $display("%s: valid=%0d perr=%0d ferr=%0d rises=%0d ack=%0d data=%02h", tag,
             n_valid - b_valid, n_perr - b_perr, n_ferr - b_ferr,
             n_rise - b_rise, n_ack - b_ack, data);
  endtask

  task automatic wait_rise(output bit ok);
    logic last;
    ok = 1'b0;
    last = ps2_clk_low;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (ps2_clk_low && !last) begin
        ok = 1'b1;
        return;
      end
      last = ps2_clk_low;
    end
  endtask

  task automatic wait_fall(output bit ok);
    logic last;
    ok = 1'b0;
    last = ps2_clk_low;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (!ps2_clk_low && last) begin
        ok = 1'b1;
        return;
      end
      last = ps2_clk_low;
    end
  endtask

  // Hold clock low for 'hold' cycles with data at 'dat_on_release', then release clock.
  task automatic host_inhibit(input int hold, input logic dat_on_release);
    host_clk  = 1'b0;
    host_data = 1'b1;
    repeat (hold) @(negedge clk);
    host_data = dat_on_release;
    repeat (4) @(negedge clk);
    host_clk = 1'b1;
  endtask

  // Host sends a frame; it changes data during each device low phase.
  // abort_k: pull clock low in the high phase of that slot (-1 = never).
  // reset_k: assert reset during the low phase of that slot (-1 = never).
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int abort_k, input int reset_k);
    logic [9:0] bits;
    bit         ok;
    bits = {stop, par, d};
    host_inhibit(HOLD, 1'b0);
    for (int k = 0; k < 10; k++) begin
      wait_rise(ok);
      check("slot_rise_seen", ok, 1'b1);
      if (!ok) begin
        host_data = 1'b1;
        return;
      end
      if (k == reset_k) begin
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_clk_low",  ps2_clk_low, 1'b0);
        check("rst_mid_data_low", ps2_data_low, 1'b0);
        check("rst_mid_busy",     busy, 1'b0);
        reset     = 1'b0;
        host_data = 1'b1;
        return;
      end
      host_data = bits[k];
      if (k == abort_k - 1) begin
        wait_fall(ok);
        check("abort_fall_seen", ok, 1'b1);
        repeat (2) @(negedge clk);
        host_clk = 1'b0;
        repeat (DIV) @(negedge clk);
        host_clk  = 1'b1;
        host_data = 1'b1;
        return;
      end
    end
    wait_rise(ok);
    check("stop_rise_seen", ok, 1'b1);
    host_data = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_low",  ps2_clk_low, 1'b0);
    check("rst_data_low", ps2_data_low, 1'b0);
    check("rst_data",     data, 8'h00);
    check("rst_valid",    valid, 1'b0);
    check("rst_perr",     parity_err, 1'b0);
    check("rst_ferr",     frame_err, 1'b0);
    check("rst_busy",     busy, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Short inhibit (below RTS time): no request
    snap();
    host_inhibit(60, 1'b0);
    host_data = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check_events("short_inhibit", 0, 0, 0, 0, 0);

    // Long inhibit with data high on release: plain inhibit
    snap();
    host_inhibit(HOLD, 1'b1);
    repeat (3 * DIV) @(negedge clk);
    check_events("plain_inhibit", 0, 0, 0, 0, 0);

    // 0xED has six ones, so the odd-parity bit is 1
    snap();
    send_frame(8'hED, 1'b1, 1'b1, -1, -1);
    repeat (3 * DIV) @(negedge clk);
    check_events("frame_ED", 1, 0, 0, 12, DIV);
    check("frame_ED_data", data, 8'hED);

    // 0x5A has four ones; parity bit 0 is wrong, data must stay 0xED
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, -1, -1);
    repeat (3 * DIV) @(negedge clk);
    check_events("frame_5A_badpar", 0, 1, 0, 12, DIV);
    check("frame_5A_data_kept", data, 8'hED);

    // 0x01 has one one; parity bit 0 is correct (checks LSB-first order)
    snap();
    send_frame(8'h01, 1'b0, 1'b1, -1, -1);
    repeat (3 * DIV) @(negedge clk);
    check_events("frame_01", 1, 0, 0, 12, DIV);
    check("frame_01_data", data, 8'h01);

    // Stop bit 0: frame error, no ACK slot
    snap();
    send_frame(8'h3C, 1'b1, 1'b0, -1, -1);
    repeat (3 * DIV) @(negedge clk);
    check_events("stop0", 0, 0, 1, 11, 0);
    check("stop0_data_kept", data, 8'h01);

    // Host pulls clock low during the high phase of slot 4
    snap();
    send_frame(8'hA5, 1'b1, 1'b1, 4, -1);
    repeat (3 * DIV) @(negedge clk);
    check_events("abort_slot4", 0, 0, 1, 4, 0);
    check("abort_clk_low", ps2_clk_low, 1'b0);

    // tx_busy blocks request detection
    snap();
    tx_busy = 1'b1;
    host_inhibit(HOLD, 1'b0);
    repeat (4) @(negedge clk);
    host_data = 1'b1;
    repeat (4) @(negedge clk);
    tx_busy = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    check_events("tx_busy_gate", 0, 0, 0, 0, 0);
    check("tx_busy_no_busy_cycles", n_busy - b_busy, 0);

    // Reset asserted in the low phase of slot 5
    snap();
    send_frame(8'h81, 1'b1, 1'b1, -1, 5);
    repeat (3 * DIV) @(negedge clk);
    check_events("reset_slot5", 0, 0, 0, 6, 0);
    check("reset_slot5_data", data, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
